ex_stage_seq: RTL and testbench

Registered, parametrised execute stage for the pipelined Y86 CPU, placed between the E pipeline register and the memory stage. It computes `valE`, holds the architectural condition codes (ZF/SF/OF) in a real register, and evaluates jump/cmov conditions from them. It adds a multi-cycle `mull` (OPL ifun 4) with a stall handshake toward decode, and a sticky halt flag.

---
 rtl/ex_stage_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_ex_stage_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_seq.sv
// Registered Y86 execute stage: computes valE, owns the ZF/SF/OF register, evaluates
// jXX/cmov conditions, runs mull as a serial shift-add multiply and holds a sticky halt.
module ex_stage_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             E_valid_i,
    input  logic [3:0]       E_icode_i,
    input  logic [3:0]       E_ifun_i,
    input  logic [WIDTH-1:0] E_valA_i,
    input  logic [WIDTH-1:0] E_valB_i,
    input  logic [WIDTH-1:0] E_valC_i,
    input  logic [3:0]       E_dstE_i,
    input  logic             set_cc_i,
    output logic             e_ready_o,
    output logic             e_valid_o,
    output logic [WIDTH-1:0] e_valE_o,
    output logic [3:0]       e_dstE_o,
    output logic             e_Cnd_o,
    output logic [2:0]       e_cc_o,
    output logic             e_halt_o,
    output logic             e_err_o
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam int unsigned W2   = 2 * WIDTH;

    localparam logic [3:0] IHalt  = 4'h0;
    localparam logic [3:0] ICmov  = 4'h2;
    localparam logic [3:0] IIrmov = 4'h3;
    localparam logic [3:0] IRmmov = 4'h4;
    localparam logic [3:0] IMrmov = 4'h5;
    localparam logic [3:0] IOpl   = 4'h6;
    localparam logic [3:0] IJxx   = 4'h7;
    localparam logic [3:0] ICall  = 4'h8;
    localparam logic [3:0] IRet   = 4'h9;
    localparam logic [3:0] IPush  = 4'hA;
    localparam logic [3:0] IPop   = 4'hB;

    typedef enum logic [1:0] {StIdle, StMul, StDone, StHalt} state_e;

    state_e           state_q, state_d;
    logic [2:0]       cc_q, cc_d;
    logic             halt_q, halt_d, valid_q, valid_d, err_q, err_d, cnd_q, cnd_d;
    logic [WIDTH-1:0] vale_q, vale_d;
    logic [3:0]       dste_q, dste_d, mdst_q, mdst_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
    logic             neg_q, neg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             zf, sf, of;
    logic             cond, illegal, alu_of, mul_of;
    logic [WIDTH-1:0] alu_res, mag_a, mag_b;
    logic [WIDTH:0]   step_sum;
    logic [W2-1:0]    prod_s;

    assign {zf, sf, of} = cc_q;

    always_comb begin
        cond = 1'b0;
        case (E_ifun_i)
            4'h0:    cond = 1'b1;
            4'h1:    cond = (sf ^ of) | zf;
            4'h2:    cond = sf ^ of;
            4'h3:    cond = zf;
            4'h4:    cond = ~zf;
            4'h5:    cond = ~(sf ^ of);
            4'h6:    cond = ~(sf ^ of) & ~zf;
            default: cond = 1'b0;
        endcase
    end

    assign illegal = (E_icode_i > IPop) || ((E_icode_i == IOpl) && (E_ifun_i > 4'h4)) ||
                     (((E_icode_i == ICmov) || (E_icode_i == IJxx)) && (E_ifun_i > 4'h6));

    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        case (E_icode_i)
            ICmov:          alu_res = E_valA_i;
            IIrmov:         alu_res = E_valC_i;
            IRmmov, IMrmov: alu_res = E_valB_i + E_valC_i;
            ICall, IPush:   alu_res = E_valB_i - WIDTH'(STEP);
            IRet, IPop:     alu_res = E_valB_i + WIDTH'(STEP);
            IOpl: begin
                case (E_ifun_i)
                    4'h0: begin
                        alu_res = E_valB_i + E_valA_i;
                        alu_of  = (E_valB_i[WIDTH-1] == E_valA_i[WIDTH-1]) &&
                                  (alu_res[WIDTH-1] != E_valB_i[WIDTH-1]);
                    end
                    4'h1: begin
                        alu_res = E_valB_i - E_valA_i;
                        alu_of  = (E_valB_i[WIDTH-1] != E_valA_i[WIDTH-1]) &&
                                  (alu_res[WIDTH-1] != E_valB_i[WIDTH-1]);
                    end
                    4'h2:    alu_res = E_valB_i & E_valA_i;
                    4'h3:    alu_res = E_valB_i ^ E_valA_i;
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    // Multiply runs on magnitudes; the sign is reapplied over the full 2*WIDTH product.
    assign mag_a    = E_valA_i[WIDTH-1] ? (~E_valA_i + WIDTH'(1)) : E_valA_i;
    assign mag_b    = E_valB_i[WIDTH-1] ? (~E_valB_i + WIDTH'(1)) : E_valB_i;
    assign step_sum = lo_q[0] ? ({1'b0, hi_q} + {1'b0, mcand_q}) : {1'b0, hi_q};
    assign prod_s   = neg_q ? (~{hi_q, lo_q} + W2'(1)) : {hi_q, lo_q};
    assign mul_of   = prod_s[W2-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}};

    always_comb begin
        state_d = state_q;
        cc_d    = cc_q;
        halt_d  = halt_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        vale_d  = vale_q;
        dste_d  = dste_q;
        cnd_d   = cnd_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        mdst_d  = mdst_q;
        unique case (state_q)
            StIdle: begin
                if (E_valid_i) begin
                    if (illegal) begin
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                        vale_d  = '0;
                        dste_d  = 4'hF;
                        cnd_d   = 1'b0;
                    end else if (E_icode_i == IHalt) begin
                        valid_d = 1'b1;
                        vale_d  = '0;
                        dste_d  = 4'hF;
                        cnd_d   = 1'b0;
                        halt_d  = 1'b1;
                        state_d = StHalt;
                    end else if ((E_icode_i == IOpl) && (E_ifun_i == 4'h4)) begin
                        state_d = StMul;
                        mcand_d = mag_b;
                        lo_d    = mag_a;
                        hi_d    = '0;
                        neg_d   = E_valA_i[WIDTH-1] ^ E_valB_i[WIDTH-1];
                        cnt_d   = CntW'(WIDTH - 1);
                        mdst_d  = E_dstE_i;
                    end else begin
                        valid_d = 1'b1;
                        vale_d  = alu_res;
                        cnd_d   = ((E_icode_i == ICmov) || (E_icode_i == IJxx)) && cond;
                        dste_d  = ((E_icode_i == ICmov) && !cond) ? 4'hF : E_dstE_i;
                        if ((E_icode_i == IOpl) && set_cc_i) begin
                            cc_d = {alu_res == '0, alu_res[WIDTH-1], alu_of};
                        end
                    end
                end
            end
            StMul: begin
                hi_d  = step_sum[WIDTH:1];
                lo_d  = {step_sum[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == '0) state_d = StDone;
            end
            StDone: begin
                valid_d = 1'b1;
                vale_d  = prod_s[WIDTH-1:0];
                dste_d  = mdst_q;
                cnd_d   = 1'b0;
                if (set_cc_i) cc_d = {prod_s[WIDTH-1:0] == '0, prod_s[WIDTH-1], mul_of};
                state_d = StIdle;
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cc_q    <= 3'b100;
            halt_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            vale_q  <= '0;
            dste_q  <= 4'hF;
            cnd_q   <= 1'b0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            mdst_q  <= 4'hF;
        end else begin
            state_q <= state_d;
            cc_q    <= cc_d;
            halt_q  <= halt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            vale_q  <= vale_d;
            dste_q  <= dste_d;
            cnd_q   <= cnd_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            mdst_q  <= mdst_d;
        end
    end

    assign e_ready_o = (state_q == StIdle);
    assign e_valid_o = valid_q;
    assign e_err_o   = err_q;
    assign e_valE_o  = vale_q;
    assign e_dstE_o  = dste_q;
    assign e_Cnd_o   = cnd_q;
    assign e_cc_o    = cc_q;
    assign e_halt_o  = halt_q;

endmodule

// File: tb/tb_ex_stage_seq.sv
// Scoreboard bench for ex_stage_seq: a behavioural Y86 model queues expected results and a
// negedge monitor compares them whenever the stage pulses e_valid_o.
module tb_ex_stage_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        E_valid_i;
    logic [3:0]  E_icode_i, E_ifun_i, E_dstE_i;
    logic [31:0] E_valA_i, E_valB_i, E_valC_i;
    logic        set_cc_i;
    logic        e_ready_o, e_valid_o, e_Cnd_o, e_halt_o, e_err_o;
    logic [31:0] e_valE_o;
    logic [3:0]  e_dstE_o;
    logic [2:0]  e_cc_o;

    typedef struct packed {
        logic [31:0] vale;
        logic [3:0]  dste;
        logic        cnd;
        logic        err;
        logic [2:0]  cc;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] model_cc;
    int         checks = 0;
    int         errors = 0;

    ex_stage_seq #(.WIDTH(32), .STEP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .E_valid_i (E_valid_i),
        .E_icode_i (E_icode_i),
        .E_ifun_i  (E_ifun_i),
        .E_valA_i  (E_valA_i),
        .E_valB_i  (E_valB_i),
        .E_valC_i  (E_valC_i),
        .E_dstE_i  (E_dstE_i),
        .set_cc_i  (set_cc_i),
        .e_ready_o (e_ready_o),
        .e_valid_o (e_valid_o),
        .e_valE_o  (e_valE_o),
        .e_dstE_o  (e_dstE_o),
        .e_Cnd_o   (e_Cnd_o),
        .e_cc_o    (e_cc_o),
        .e_halt_o  (e_halt_o),
        .e_err_o   (e_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: Y86 semantics in 64-bit integer arithmetic.
    task automatic model(input logic [3:0] ic, input logic [3:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c, input logic [3:0] dst,
                         input logic sc, output exp_t e);
        bit z, s, o, taken;
        longint sa, sb, full;
        logic [31:0] r;
        z = model_cc[2]; s = model_cc[1]; o = model_cc[0];
        case (fn)
            0: taken = 1;
            1: taken = (s != o) || z;
            2: taken = (s != o);
            3: taken = z;
            4: taken = !z;
            5: taken = (s == o);
            6: taken = (s == o) && !z;
            default: taken = 0;
        endcase
        e.vale = 0; e.dste = dst; e.cnd = 0; e.err = 0;
        if (ic > 11 || (ic == 6 && fn > 4) || ((ic == 2 || ic == 7) && fn > 6)) begin
            e.err = 1; e.dste = 4'hF;
        end else begin
            case (ic)
                0: e.dste = 4'hF;
                2: begin e.vale = a; e.cnd = taken; if (!taken) e.dste = 4'hF; end
                3: e.vale = c;
                4, 5: e.vale = b + c;
                8, 10: e.vale = b - 32'd4;
                9, 11: e.vale = b + 32'd4;
                7: e.cnd = taken;
                6: begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    case (fn)
                        0: full = sb + sa;
                        1: full = sb - sa;
                        2: full = longint'($signed(b & a));
                        3: full = longint'($signed(b ^ a));
                        default: full = sb * sa;
                    endcase
                    r = full[31:0];
                    e.vale = r;
                    if (sc) model_cc = {r == 0, r[31], full != longint'($signed(r))};
                end
                default: ;
            endcase
        end
        e.cc = model_cc;
    endtask

    task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c, input logic [3:0] dst,
                         input logic sc, input bit expect_res);
        exp_t e;
        int n = 0;
        while (!e_ready_o && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_before_issue", e_ready_o, 1);
        if (expect_res) begin
            model(ic, fn, a, b, c, dst, sc, e);
            exp_q.push_back(e);
        end
        E_valid_i = 1; E_icode_i = ic; E_ifun_i = fn;
        E_valA_i = a; E_valB_i = b; E_valC_i = c; E_dstE_i = dst; set_cc_i = sc;
        @(posedge clk); #1;
        // Garbage on the operands while not valid must not be sampled.
        E_valid_i = 0; E_icode_i = 4'($urandom); E_ifun_i = 4'($urandom);
        E_valA_i = $urandom; E_valB_i = $urandom; E_valC_i = $urandom;
        E_dstE_i = 4'($urandom);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!e_ready_o && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("wait_ready", e_ready_o, 1);
    endtask

    function automatic logic [31:0] pickv();
        case ($urandom_range(0, 6))
            0: pickv = 32'h0;
            1: pickv = 32'h8000_0000;
            2: pickv = 32'h7FFF_FFFF;
            3: pickv = 32'hFFFF_FFFF;
            4: pickv = 32'($urandom_range(0, 100)) - 32'd50;
            default: pickv = $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && e_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: e_valid_o=1 with no result pending (t=%0t)",
                         $time);
            end else begin
                e = exp_q.pop_front();
                chk("valE", e_valE_o, e.vale);
                chk("dstE", e_dstE_o, e.dste);
                chk("Cnd", e_Cnd_o, e.cnd);
                chk("err", e_err_o, e.err);
                chk("cc", e_cc_o, e.cc);
            end
        end else if (!rst && e_err_o) begin
            checks++;
            errors++;
            $display("FAIL err_without_valid: e_err_o=1 with e_valid_o=0 (t=%0t)", $time);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, pulses, n;
        logic [3:0] ic, fn;
        rst = 1; E_valid_i = 0; E_icode_i = 0; E_ifun_i = 0; E_dstE_i = 0;
        E_valA_i = 0; E_valB_i = 0; E_valC_i = 0; set_cc_i = 0;
        model_cc = 3'b100;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        chk("rst_cc", e_cc_o, 3'b100);
        chk("rst_dstE", e_dstE_o, 4'hF);
        chk("rst_ready", e_ready_o, 1);
        chk("rst_valid", e_valid_o, 0);
        chk("rst_valE", e_valE_o, 0);
        chk("rst_Cnd", e_Cnd_o, 0);
        chk("rst_halt", e_halt_o, 0);
        chk("rst_err", e_err_o, 0);

        // subl overflow, then jl back-to-back sees the freshly written CC.
        issue(4'h6, 4'h1, 32'h1, 32'h8000_0000, 32'h0, 4'h2, 1, 1);
        chk("subl_valE", e_valE_o, 32'h7FFF_FFFF);
        chk("subl_cc", e_cc_o, 3'b001);
        issue(4'h7, 4'h2, 32'h0, 32'h0, 32'h40, 4'hF, 1, 1);
        chk("jl_cnd", e_Cnd_o, 1);
        issue(4'h2, 4'h3, 32'h5, 32'h0, 32'h0, 4'h3, 1, 1);
        chk("cmove_dstE", e_dstE_o, 4'hF);
        chk("cmove_valE", e_valE_o, 32'h5);

        // mull -3*7: ready low 33 cycles, result with the ready rise.
        issue(4'h6, 4'h4, 32'd7, 32'hFFFF_FFFD, 32'h0, 4'h1, 1, 1);
        cnt = 0;
        while (!e_ready_o && cnt < 100) begin
            cnt++; @(posedge clk); #1;
        end
        chk("mul_ready_low_cycles", cnt, 33);
        chk("mul_valid", e_valid_o, 1);
        chk("mul_valE", e_valE_o, 32'hFFFF_FFEB);
        chk("mul_cc", e_cc_o, 3'b010);
        issue(4'h6, 4'h4, 32'h1_0000, 32'h1_0000, 32'h0, 4'h4, 1, 1);
        wait_ready();
        chk("mul_ovf_valE", e_valE_o, 32'h0);
        chk("mul_ovf_cc", e_cc_o, 3'b101);

        for (int i = 0; i < 80; i++) begin
            ic = 4'($urandom_range(1, 11));
            if ($urandom_range(0, 14) == 0) ic = 4'($urandom_range(12, 15));
            if (ic == 6) fn = 4'($urandom_range(0, 5));
            else if (ic == 2 || ic == 7) fn = 4'($urandom_range(0, 7));
            else fn = 4'($urandom);
            issue(ic, fn, pickv(), pickv(), pickv(), 4'($urandom),
                  $urandom_range(0, 3) != 0, 1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        wait_ready();
        repeat (2) @(posedge clk);
        #1;

        // Reset five cycles into a multiply: no result, CC back to reset value.
        issue(4'h6, 4'h4, 32'd9, 32'd9, 32'h0, 4'h5, 1, 0);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_cc = 3'b100;
        chk("rstmul_ready", e_ready_o, 1);
        chk("rstmul_cc", e_cc_o, 3'b100);
        chk("rstmul_dstE", e_dstE_o, 4'hF);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (e_valid_o) pulses++;
        end
        chk("rstmul_no_pulse", pulses, 0);
        chk("rstmul_cc_after", e_cc_o, 3'b100);
        @(posedge clk); #1;

        // Illegal icode: error pulse, CC untouched.
        issue(4'h6, 4'h0, 32'h1, 32'h2, 32'h0, 4'h6, 1, 1);
        issue(4'hC, 4'h0, 32'h55, 32'h66, 32'h77, 4'h2, 1, 1);
        chk("illegal_err", e_err_o, 1);
        chk("illegal_valE", e_valE_o, 0);
        chk("illegal_cc", e_cc_o, 3'b000);

        // Halt is sticky and blocks further accepts.
        issue(4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 4'h1, 1, 1);
        chk("halt_flag", e_halt_o, 1);
        chk("halt_ready", e_ready_o, 0);
        E_valid_i = 1; E_icode_i = 4'h6; E_ifun_i = 4'h0;
        E_valA_i = 32'h3; E_valB_i = 32'hFFFF_FFFD; E_dstE_i = 4'h2; set_cc_i = 1;
        repeat (6) begin @(posedge clk); #1; end
        E_valid_i = 0;
        chk("halt_sticky", e_halt_o, 1);
        chk("halt_ready_held", e_ready_o, 0);
        chk("halt_cc_kept", e_cc_o, 3'b000);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
